// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants and the fetch sequencer state encoding.
// Imported by the fetch unit and by main control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch unit is the master; the memory is the slave.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC select: jump target, then taken branch, then sequential.
// Kept free of state so a pipelined fetch stage can reuse it.
module mips_next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [25:0]       instr_idx,
  input  logic              pcsrc,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  // Word offset sign-extended and scaled to bytes; overflow wraps.
  assign br_off = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign br_tgt = pc_plus4 + br_off;
  assign j_tgt  = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)       next_pc = j_tgt;
    else if (pcsrc) next_pc = br_tgt;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch sequencer for the non-pipelined MIPS core: owns the PC,
// fetches one word at a time over the imem handshake and hands it to main control.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                pcsrc,
  input  logic                jump,
  mips_fetch_unit_if.master   imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          func,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic [31:0]         retire_cnt
);

  fetch_state_t      state;
  logic              req;
  logic [ADDR_W-1:0] next_pc;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + ADDR_W'(4);
  assign opcode         = instr[31:26];
  assign func           = instr[5:0];

  mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_idx (instr[25:0]),
    .pcsrc     (pcsrc),
    .jump      (jump),
    .next_pc   (next_pc)
  );

  // req is registered so it drops in the same cycle reset asserts and
  // rises on the edge that enters FETCH; zero-wait acks land in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          req   <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req         <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // Acks arriving here are stray and fall through untouched.
          if (!stall) begin
            pc          <= next_pc;
            retire_cnt  <= retire_cnt + 32'd1;
            instr_valid <= 1'b0;
            req         <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: stimulus queues expected fetch addresses
// and instructions, a negedge monitor checks them as the DUT presents them.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retire_cnt;

  mips_fetch_unit_if #(.ADDR_W(32)) bus ();

  mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .func        (func),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exec_t;

  logic [31:0] addr_q[$];
  exec_t       exec_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          vld_cnt = 0;
  int          exp_ret = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, exp);
  endtask

  // Monitor: fetch handshakes and instr_valid rising edges.
  initial begin
    logic  vld_d;
    exec_t e;
    logic [31:0] a;
    vld_d = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        vld_d = 1'b0;
      end else begin
        if (instr_valid) vld_cnt++;
        if (bus.imem_req && bus.imem_ack) begin
          if (addr_q.size() == 0) check("unexpected_fetch", 32'd1, 32'd0);
          else begin
            a = addr_q.pop_front();
            check("fetch_addr", bus.imem_addr, a);
          end
        end
        if (instr_valid && !vld_d) begin
          if (exec_q.size() == 0) check("unexpected_exec", 32'd1, 32'd0);
          else begin
            e = exec_q.pop_front();
            check("exec_instr", instr, e.word);
            check("exec_pc", pc, e.addr);
            check("exec_opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
          end
        end
        vld_d = instr_valid;
      end
    end
  end

  // One instruction: wait for req, optional wait states, ack, EXEC with optional stall.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits,
                          input logic br, input logic jp, input int stalls, input logic spurious);
    int t = 0;
    while (!bus.imem_req && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!bus.imem_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    for (int w = 0; w < waits; w++) begin
      check("wait_req", {31'd0, bus.imem_req}, 32'd1);
      check("wait_addr", bus.imem_addr, addr);
      @(posedge clk); #1;
    end
    addr_q.push_back(addr);
    exec_q.push_back('{addr, word});
    bus.imem_ack = 1'b1;
    bus.imem_rdata = word;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    pcsrc = br;
    jump = jp;
    stall = (stalls > 0);
    if (spurious) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
    end
    for (int s = 0; s < stalls; s++) begin
      @(posedge clk); #1;
      check("stall_pc", pc, addr);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_retire", retire_cnt, exp_ret);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    jump = 1'b0;
    bus.imem_ack = 1'b0;
    exp_ret++;
    check("retire_cnt", retire_cnt, exp_ret);
    if (spurious) check("spurious_instr", instr, word);
  endtask

  initial begin
    int c0, v0, t;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    #2 rst = 1'b1;
    #1;
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retire", retire_cnt, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    t = 0;
    while (!bus.imem_req && t < 10) begin
      @(posedge clk); #1; t++;
    end
    c0 = cyc; v0 = vld_cnt;
    do_fetch(32'h0000_0000, 32'h2001_0005, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0004, 32'h8C22_0000, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0008, 32'hAC22_0004, 0, 0, 0, 0, 0);
    check("seq_cycles", cyc - c0, 32'd6);
    check("seq_valid_pulses", vld_cnt - v0, 32'd3);
    check("seq_retire", retire_cnt, 32'd3);

    do_fetch(32'h0000_000C, 32'h0800_0010, 0, 0, 1, 0, 0);  // j 0x40
    do_fetch(32'h0000_0040, 32'h1000_FFFE, 0, 1, 0, 0, 0);  // beq -2 taken
    do_fetch(32'h0000_003C, 32'h0000_0020, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0040, 32'h1000_FFFE, 0, 0, 0, 0, 0);  // beq -2 not taken
    do_fetch(32'h0000_0044, 32'h0BFF_FFFF, 0, 0, 1, 0, 0);  // j 0x0FFFFFFC
    do_fetch(32'h0FFF_FFFC, 32'h2001_0001, 5, 0, 0, 0, 0);  // 5 wait states
    do_fetch(32'h1000_0000, 32'h1000_0003, 0, 1, 0, 3, 0);  // beq +3, stalled
    do_fetch(32'h1000_0010, 32'h0800_0100, 0, 1, 1, 0, 0);  // jump beats branch
    check("jump_prio_req", {31'd0, bus.imem_req}, 32'd1);
    check("jump_prio_addr", bus.imem_addr, 32'h1000_0400);

    // Reset with the fetch at 0x10000400 still unacknowledged.
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_retire", retire_cnt, 32'h0);
    exp_ret = 0;
    @(posedge clk); #1 rst = 1'b0;
    #1 check("idle_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    check("refetch_req", {31'd0, bus.imem_req}, 32'd1);
    check("refetch_addr", bus.imem_addr, 32'h0);

    do_fetch(32'h0000_0000, 32'h1000_FFFE, 0, 1, 0, 0, 0);  // underflow to FFFFFFFC
    do_fetch(32'hFFFF_FFFC, 32'h2001_0002, 0, 0, 0, 0, 1);  // wrap, spurious ack
    check("wrap_addr", bus.imem_addr, 32'h0);
    do_fetch(32'h0000_0000, 32'h0000_0020, 0, 0, 0, 0, 0);
    check("final_addr", bus.imem_addr, 32'h0000_0004);
    check("final_retire", retire_cnt, 32'd3);
    @(negedge clk);
    check("sb_addr_drain", addr_q.size(), 32'd0);
    check("sb_exec_drain", exec_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
